// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The master is the pipeline side; the slave is the execute unit.
interface muldiv_unit_if;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  modport master (
    output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    input  stall_o, busy_o, done_o, result_o, rd_addr_o
  );

  modport slave (
    input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    output stall_o, busy_o, done_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// M-extension execute unit: MUL* in MUL_CYCLES cycles, DIV/REM via a 32-step restoring divider.
// Stalls the front of the pipe until the result is ready; flush aborts without a done pulse.
module muldiv_unit #(
  parameter int MUL_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  count;
  logic [1:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem_q;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] result;
  logic [4:0]  rd_out;

  logic        accept;
  logic        in_signed;
  logic        div_zero;
  logic        div_ovf;
  logic        special;
  logic [31:0] special_res;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] rem_n;
  logic [31:0] quo_n;
  logic [31:0] div_res;
  logic [31:0] done_res;
  logic [4:0]  done_rd;

  // Low 64 bits of a 64x64 product equal the true product of the extended 32-bit operands.
  function automatic logic [31:0] mul_res(input logic [1:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic        sa;
    logic        sb;
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] p;
    sa  = (f3 != 2'b11);
    sb  = !f3[1];
    a64 = {{32{sa & a[31]}}, a};
    b64 = {{32{sb & b[31]}}, b};
    p   = a64 * b64;
    return (f3 == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  assign accept    = (state == S_IDLE) && bus.start_i && !bus.flush_i;
  assign in_signed = !bus.funct3_i[0];
  assign div_zero  = (bus.rs2_data_i == 32'd0);
  assign div_ovf   = in_signed && (bus.rs1_data_i == 32'h8000_0000) &&
                     (bus.rs2_data_i == 32'hFFFF_FFFF);
  assign special   = bus.funct3_i[2] && (div_zero || div_ovf);
  assign abs_a     = (in_signed && bus.rs1_data_i[31]) ? -bus.rs1_data_i : bus.rs1_data_i;
  assign abs_b     = (in_signed && bus.rs2_data_i[31]) ? -bus.rs2_data_i : bus.rs2_data_i;

  always_comb begin
    special_res = 32'd0;
    if (div_zero)
      special_res = bus.funct3_i[1] ? bus.rs1_data_i : 32'hFFFF_FFFF;
    else
      special_res = bus.funct3_i[1] ? 32'd0 : 32'h8000_0000;
  end

  // One restoring step: a_q shifts dividend bits out and quotient bits in.
  assign shifted = {rem_q, a_q[31]};
  assign diff    = shifted - {1'b0, b_q};
  assign q_bit   = !diff[32];
  assign rem_n   = q_bit ? diff[31:0] : shifted[31:0];
  assign quo_n   = {a_q[30:0], q_bit};
  assign div_res = f3_q[1] ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);

  always_comb begin
    done_res = result;
    done_rd  = rd_q;
    case (state)
      S_IDLE: begin
        done_res = bus.funct3_i[2] ? special_res
                                   : mul_res(bus.funct3_i[1:0], bus.rs1_data_i, bus.rs2_data_i);
        done_rd  = bus.rd_addr_i;
      end
      S_MUL:   done_res = mul_res(f3_q, a_q, b_q);
      S_DIV:   done_res = div_res;
      default: done_res = result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!bus.funct3_i[2]) state_nxt = (MUL_CYCLES == 1) ? S_DONE : S_MUL;
          else                  state_nxt = special ? S_DONE : S_DIV;
        end
      end
      S_MUL: begin
        if (bus.flush_i)            state_nxt = S_IDLE;
        else if (count == MUL_LAST) state_nxt = S_DONE;
      end
      S_DIV: begin
        if (bus.flush_i)         state_nxt = S_IDLE;
        else if (count == 5'd31) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.stall_o = accept || (state == S_MUL) || (state == S_DIV);
    bus.busy_o  = (state != S_IDLE);
    bus.done_o  = (state == S_DONE) && !bus.flush_i;
  end

  assign bus.result_o  = result;
  assign bus.rd_addr_o = rd_out;

  // Multiply counter starts at 1 so the acceptance cycle counts toward MUL_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 5'd0;
      f3_q   <= 2'd0;
      rd_q   <= 5'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      rem_q  <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= 32'd0;
      rd_out <= 5'd0;
    end else begin
      if (state_nxt == S_DONE) begin
        result <= done_res;
        rd_out <= done_rd;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            f3_q <= bus.funct3_i[1:0];
            rd_q <= bus.rd_addr_i;
            if (bus.funct3_i[2]) begin
              count <= 5'd0;
              a_q   <= abs_a;
              b_q   <= abs_b;
              rem_q <= 32'd0;
              neg_q <= in_signed && (bus.rs1_data_i[31] ^ bus.rs2_data_i[31]);
              neg_r <= in_signed && bus.rs1_data_i[31];
            end else begin
              count <= 5'd1;
              a_q   <= bus.rs1_data_i;
              b_q   <= bus.rs2_data_i;
            end
          end
        end
        S_MUL: count <= count + 5'd1;
        S_DIV: begin
          count <= count + 5'd1;
          a_q   <= quo_n;
          rem_q <= rem_n;
        end
        default: count <= 5'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, special divides, flush and reset behaviour.
module tb_muldiv_unit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  muldiv_unit_if bus ();

  muldiv_unit #(.MUL_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op on the next cycle (cycle 0) and wait for done_o; operands are scrambled after cycle 0.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold, output int lat, output int stalls,
                        output logic [31:0] res, output logic [4:0] rda);
    lat    = -1;
    stalls = 0;
    res    = 32'd0;
    rda    = 5'd0;
    @(posedge clk); #1;
    bus.start_i    = 1'b1;
    bus.funct3_i   = f3;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_addr_i  = rd;
    #1;
    if (bus.stall_o) stalls++;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (!hold) bus.start_i = 1'b0;
      bus.funct3_i   = ~f3;
      bus.rs1_data_i = 32'hDEAD_BEEF;
      bus.rs2_data_i = 32'h1234_5678;
      bus.rd_addr_i  = ~rd;
      #1;
      if (bus.done_o) begin
        lat = c;
        res = bus.result_o;
        rda = bus.rd_addr_o;
      end
      if (bus.stall_o) stalls++;
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done_o); end
    n_cmp++; if (bus.result_o !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", bus.result_o); end
    n_cmp++; if (bus.rd_addr_o !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %0d want 0", bus.rd_addr_o); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat; int st; logic [31:0] r; logic [4:0] rd;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd4, 1'b0, lat, st, r, rd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mul_latency got %0d want 2", lat); end
    n_cmp++; if (r !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mul_result got %h want ffffffeb", r); end
    n_cmp++; if (st !== 2) begin n_bad++; $display("FAIL mul_stall_cycles got %0d want 2", st); end
    n_cmp++; if (rd !== 5'd4) begin n_bad++; $display("FAIL mul_rd got %0d want 4", rd); end
  endtask

  task automatic test_mulh();
    int lat; int st; logic [31:0] r; logic [4:0] rd;
    logic [2:0]  f3s [3] = '{3'b001, 3'b010, 3'b011};
    logic [31:0] exp [3] = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000};
    for (int i = 0; i < 3; i++) begin
      run_op(f3s[i], 32'h8000_0000, 32'h8000_0000, 5'd10 + 5'(i), 1'b0, lat, st, r, rd);
      n_cmp++; if (r !== exp[i]) begin n_bad++; $display("FAIL mulh_result f3=%0d got %h want %h", f3s[i], r, exp[i]); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mulh_latency f3=%0d got %0d want 2", f3s[i], lat); end
    end
  endtask

  task automatic test_div();
    int lat; int st; logic [31:0] r; logic [4:0] rd;
    logic [2:0]  f3s [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'd20, 1'b0, lat, st, r, rd);
      n_cmp++; if (r !== exp[i]) begin n_bad++; $display("FAIL div_result f3=%0d got %h want %h", f3s[i], r, exp[i]); end
      n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div_latency f3=%0d got %0d want 33", f3s[i], lat); end
    end
    n_cmp++; if (st !== 33) begin n_bad++; $display("FAIL div_stall_cycles got %0d want 33", st); end
  endtask

  task automatic test_flush();
    int lat; bit seen_done; logic [31:0] r;
    seen_done = 1'b0;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.rs1_data_i = 32'd100; bus.rs2_data_i = 32'd7;
    bus.rd_addr_i = 5'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      if (c == 10) bus.flush_i = 1'b1;
      #1;
      if (bus.done_o) seen_done = 1'b1;
    end
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    #1;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", bus.stall_o); end
    n_cmp++; if (seen_done || bus.done_o) begin n_bad++; $display("FAIL flush_done got 1 want 0"); end
    n_cmp++; if (bus.result_o !== 32'd2) begin n_bad++; $display("FAIL flush_result got %h want 2", bus.result_o); end
    // Back-to-back start in the cycle right after the flush.
    bus.start_i = 1'b1; bus.funct3_i = 3'b000; bus.rs1_data_i = 32'd6; bus.rs2_data_i = 32'd7;
    bus.rd_addr_i = 5'd8;
    #1;
    n_cmp++; if (bus.stall_o !== 1'b1) begin n_bad++; $display("FAIL b2b_stall got %b want 1", bus.stall_o); end
    lat = -1; r = 32'd0;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      #1;
      if (bus.done_o) begin lat = c; r = bus.result_o; end
    end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL b2b_latency got %0d want 2", lat); end
    n_cmp++; if (r !== 32'd42) begin n_bad++; $display("FAIL b2b_result got %h want 2a", r); end
  endtask

  task automatic test_special();
    int lat; int st; logic [31:0] r; logic [4:0] rd;
    logic [2:0]  f3s [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'd7, 1'b0, lat, st, r, rd);
      n_cmp++; if (r !== exp[i]) begin n_bad++; $display("FAIL special_result i=%0d got %h want %h", i, r, exp[i]); end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL special_latency i=%0d got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.funct3_i = 3'b100; bus.rs1_data_i = 32'd1000; bus.rs2_data_i = 32'd3;
    bus.rd_addr_i = 5'd31;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_stall got %b want 0", bus.stall_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %b want 0", bus.done_o); end
    n_cmp++; if (bus.result_o !== 32'd0) begin n_bad++; $display("FAIL rstmid_result got %h want 0", bus.result_o); end
    n_cmp++; if (bus.rd_addr_o !== 5'd0) begin n_bad++; $display("FAIL rstmid_rd got %0d want 0", bus.rd_addr_o); end
  endtask

  task automatic test_hold_start();
    int lat; int st; logic [31:0] r; logic [4:0] rd; bit extra;
    run_op(3'b000, 32'd3, 32'd5, 5'd9, 1'b1, lat, st, r, rd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL hold_latency got %0d want 2", lat); end
    n_cmp++; if (r !== 32'd15) begin n_bad++; $display("FAIL hold_result got %h want f", r); end
    n_cmp++; if (rd !== 5'd9) begin n_bad++; $display("FAIL hold_rd got %0d want 9", rd); end
    @(posedge clk); #2;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL hold_retrigger_busy got %b want 0", bus.busy_o); end
    extra = 1'b0;
    repeat (4) begin
      @(posedge clk); #2;
      if (bus.done_o || bus.busy_o) extra = 1'b1;
    end
    n_cmp++; if (extra) begin n_bad++; $display("FAIL hold_retrigger got activity want idle"); end
  endtask

  task automatic test_flush_done();
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.funct3_i = 3'b000; bus.rs1_data_i = 32'd2; bus.rs2_data_i = 32'd3;
    bus.rd_addr_i = 5'd1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    #1;
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL flushdone_done got %b want 0", bus.done_o); end
    n_cmp++; if (bus.stall_o !== 1'b0) begin n_bad++; $display("FAIL flushdone_stall got %b want 0", bus.stall_o); end
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    #1;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL flushdone_busy got %b want 0", bus.busy_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start_i    = 1'b0;
    bus.funct3_i   = 3'b000;
    bus.rs1_data_i = 32'd0;
    bus.rs2_data_i = 32'd0;
    bus.rd_addr_i  = 5'd0;
    bus.flush_i    = 1'b0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_flush();
    test_special();
    test_hold_start();
    test_reset_mid();
    test_flush_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
